pipe_dcache_wt: RTL

Direct-mapped, write-through, no-write-allocate data cache between the MEM stage of pipelined_computer and the data-memory/IO bus. It serves CPU loads and stores, stalls the pipeline on misses and writes, and refills whole lines from the backing memory with a ready handshake. It replaces the direct CPU-to-dmem connection in the with-cache build.

---
 rtl/pipe_cache_pkg.sv | 27 ++
 rtl/pipe_dcache_array.sv | 49 ++++
 rtl/pipe_dcache_wt.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pipe_cache_pkg.sv
// Shared definitions for the pipelined data cache: FSM state encoding and
// address-split width helpers.
package pipe_cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2,
    WDONE  = 2'd3
  } state_e;

  localparam int ADDR_W = 32;
  localparam int BYTE_W = 2;

  function automatic int off_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int lines, input int words);
    return ADDR_W - BYTE_W - $clog2(lines) - $clog2(words);
  endfunction

endpackage

// File: rtl/pipe_dcache_array.sv
// Tag/valid/data storage for the direct-mapped data cache: combinational
// read port, single word write port, line-fill tag/valid set.
module pipe_dcache_array
  import pipe_cache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 4,
  parameter int IDX_W = idx_w(LINES),
  parameter int OFF_W = off_w(WORDS),
  parameter int TAG_W = tag_w(LINES, WORDS)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic [OFF_W-1:0] rd_off_i,
  output logic             rd_valid_o,
  output logic [TAG_W-1:0] rd_tag_o,
  output logic [31:0]      rd_data_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [OFF_W-1:0] wr_off_i,
  input  logic [31:0]      wr_data_i,
  input  logic             fill_i,
  input  logic [TAG_W-1:0] fill_tag_i
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES][WORDS];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
    end else if (fill_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tags and data need no reset: an entry is only consulted while its valid bit is set.
  always_ff @(posedge clock) begin
    if (wr_en_i) data_q[wr_idx_i][wr_off_i] <= wr_data_i;
    if (fill_i)  tag_q[wr_idx_i] <= fill_tag_i;
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i][rd_off_i];

endmodule

// File: rtl/pipe_dcache_wt.sv
// Direct-mapped write-through, no-write-allocate data cache for the MEM stage.
// Optional DCACHE_STATS_EN adds hit_count/miss_count outputs.
module pipe_dcache_wt
  import pipe_cache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        cpu_re,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int OFF_W = off_w(WORDS);
  localparam int IDX_W = idx_w(LINES);
  localparam int TAG_W = tag_w(LINES, WORDS);
  localparam int WA_W  = ADDR_W - BYTE_W;

  state_e           state_q;
  logic [OFF_W-1:0] cnt_q;
  logic [WA_W-1:0]  addr_q;
  logic [31:0]      wdata_q;

  logic [WA_W-1:0]  look_wa;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_data;
  logic             hit, ld_hit, start_write, start_refill, last_word;
  logic             arr_we, fill;
  logic [OFF_W-1:0] wr_off;
  logic [31:0]      wr_data;
  logic [1:0]       unused_byte_bits;

  assign unused_byte_bits = cpu_addr[1:0];

  // In IDLE the live CPU address is looked up; otherwise the latched one.
  assign look_wa      = (state_q == IDLE) ? cpu_addr[31:2] : addr_q;
  assign hit          = rd_valid && (rd_tag == look_wa[OFF_W+IDX_W +: TAG_W]);
  assign start_write  = (state_q == IDLE) && cpu_we;
  assign ld_hit       = (state_q == IDLE) && !cpu_we && cpu_re && hit;
  assign start_refill = (state_q == IDLE) && !cpu_we && cpu_re && !hit;
  assign last_word    = (cnt_q == OFF_W'(WORDS - 1));

  assign fill    = (state_q == REFILL) && mem_ready && last_word;
  assign arr_we  = mem_ready && ((state_q == REFILL) || ((state_q == WRITE) && hit));
  assign wr_off  = (state_q == REFILL) ? cnt_q : addr_q[OFF_W-1:0];
  assign wr_data = (state_q == REFILL) ? mem_rdata : wdata_q;

  pipe_dcache_array #(
    .LINES(LINES),
    .WORDS(WORDS)
  ) u_array (
    .clock      (clock),
    .resetn     (resetn),
    .rd_idx_i   (look_wa[OFF_W +: IDX_W]),
    .rd_off_i   (look_wa[OFF_W-1:0]),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .wr_en_i    (arr_we),
    .wr_idx_i   (addr_q[OFF_W +: IDX_W]),
    .wr_off_i   (wr_off),
    .wr_data_i  (wr_data),
    .fill_i     (fill),
    .fill_tag_i (addr_q[OFF_W+IDX_W +: TAG_W])
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_write) begin
            state_q <= WRITE;
          end else if (start_refill) begin
            state_q <= REFILL;
            cnt_q   <= '0;
          end
        end
        REFILL: begin
          if (mem_ready) begin
            cnt_q <= cnt_q + OFF_W'(1);
            if (last_word) state_q <= IDLE;
          end
        end
        WRITE:   if (mem_ready) state_q <= WDONE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (start_write || start_refill) begin
      addr_q  <= cpu_addr[31:2];
      wdata_q <= cpu_wdata;
    end
  end

  // Outputs are forced to zero while reset is asserted, whatever the inputs.
  always_comb begin
    cpu_stall = 1'b0;
    cpu_rdata = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (resetn) begin
      case (state_q)
        IDLE: begin
          cpu_stall = cpu_we || (cpu_re && !hit);
          if (ld_hit) cpu_rdata = rd_data;
        end
        REFILL: begin
          cpu_stall = 1'b1;
          mem_re    = 1'b1;
          mem_addr  = {addr_q[WA_W-1:OFF_W], cnt_q, 2'b00};
        end
        WRITE: begin
          cpu_stall = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = {addr_q, 2'b00};
          mem_wdata = wdata_q;
        end
        default: ;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_q, miss_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (ld_hit)       hit_q  <= hit_q + 32'd1;
      if (start_refill) miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`endif

endmodule
